tile_hash_gen: RTL and testbench
================================

// Module: tile_hash_gen
// PURPOSE
//  Consumes the per-tile byte stream produced by the VRAM tile snooper and computes a 32-bit FNV-1a hash per tile.
//  Tags each hash with tile index, text-range flag and length-error flag; queues the result for the text lookup stage.
//  Sits between the snooper (no backpressure) and the hash-lookup table (valid/ready).
// PARAMETERS
//  TILE_BYTES  16  bytes per tile (GB 2bpp = 16, GBA 4bpp = 32)
//  FIFO_DEPTH  4   result queue entries; power of two, >= 2
// PORTS
//  clk                  in   1   system clock
//  rst                  in   1   synchronous reset, active-high
//  in_valid             in   1   stream byte valid (snooper hash_data_valid)
//  in_data              in   8   stream byte
//  in_last              in   1   last byte of tile
//  in_tile_index        in   9   tile index from snooper, sampled on first byte
//  cfg_enable           in   1   block enable; 0 = ignore input, abort tile in progress
//  cfg_text_only        in   1   1 = discard results whose tile is outside text range
//  cfg_text_tile_start  in   9   first text-font tile index
//  cfg_text_tile_end    in   9   last text-font tile index
//  res_valid            out  1   result available
//  res_ready            in   1   consumer accepts result
//  res_hash             out  32  FNV-1a hash
//  res_tile_index       out  9   tile that produced hash
//  res_in_text          out  1   tile index within [start,end] inclusive
//  res_len_err          out  1   byte count at in_last != TILE_BYTES
//  drop_count           out  16  results lost to full FIFO, saturating
//  busy                 out  1   tile accumulation in progress
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, acc = FNV_OFFSET, state IDLE. Reset mid-tile discards the partial tile.
//  Hash: acc = (acc ^ {24'b0,byte}) * FNV_PRIME, truncated to 32 bits, one byte per cycle.
//  FSM IDLE/ACCUM:
//   IDLE:  in_valid & cfg_enable -> latch in_tile_index, acc = step(FNV_OFFSET), cnt = 1; go ACCUM (stay IDLE if in_last).
//   ACCUM: in_valid -> acc = step(acc), cnt++, saturating at TILE_BYTES+1. in_last -> IDLE.
//   Cycles with in_valid=0 in ACCUM hold state; there is no timeout.
//   cfg_enable=0 -> IDLE next cycle; partial tile discarded, nothing pushed.
//  Completion:
//   - On the in_last cycle, register pend = 1 with final hash, latched index, in_text, and len_err = (cnt_incl_last != TILE_BYTES).
//   - Push to FIFO the following cycle, so res_valid rises 2 cycles after in_last on an empty FIFO.
//   - A new first byte in the push cycle is accepted normally; back-to-back tiles never stall.
//   - in_last with cfg_text_only=1 and in_text=0: result dropped silently; drop_count is not incremented.
//  FIFO: first-word fall-through; res_* shows the head entry while res_valid=1.
//   - Pop on res_valid & res_ready.
//   - Push when full with no pop: entry dropped, drop_count++ (saturates at 16'hFFFF).
//   - Push when full with a pop in the same cycle: accepted, no drop.
//   - Empty: res_valid = 0; res_* fields hold their last value and are don't-care.
//  busy = (state == ACCUM) | pend.
//  Counter width: $clog2(TILE_BYTES+2); FIFO pointers carry one extra wrap bit.
// STRUCTURE
//  Package gbt_hash_pkg: FNV_OFFSET=32'h811C9DC5, FNV_PRIME=32'h01000193,
//   typedef struct packed tile_hash_res_t {hash, tile_index, in_text, len_err},
//   function fnv1a_step(acc, byte).
//  Sub-module: tile_hash_fifo (sync FWFT FIFO of tile_hash_res_t, DEPTH param).
//  Top level holds the FSM, accumulator, pend register and drop counter.
// TESTING
//  1. TILE_BYTES=1, single byte 0x61 with in_last, idx 9'd5 -> res_hash 32'hE40C292C, idx 5, len_err 0, res_valid 2 cycles later.
//  2. TILE_BYTES=1, byte 0x00 -> 32'h050C5D1F. Default 16 bytes 0x00..0x0F -> matches gbt_hash_pkg golden model.
//  3. 16-byte tile, in_last on the 12th byte -> len_err 1. 20 bytes, last on the 20th -> len_err 1, hash still pushed.
//  4. res_ready=0, 6 tiles with FIFO_DEPTH=4 -> 4 queued, drop_count=2. Then res_ready=1 -> 4 results in order, idx preserved.
//  5. cfg_text_only=1, range 9'd32..9'd95, tiles 31/32/95/96 -> only 32 and 95 emitted; drop_count stays 0.
//  6. cfg_enable dropped or rst pulsed at byte 8 -> no result; next full tile hashes correctly from FNV_OFFSET.

Source files
------------

// File: rtl/gbt_hash_pkg.sv
// Shared types and FNV-1a helpers for the tile hash path.
// Used by the hash generator and its result queue.
package gbt_hash_pkg;

    localparam logic [31:0] FNV_OFFSET = 32'h811C9DC5;
    localparam logic [31:0] FNV_PRIME  = 32'h01000193;

    typedef struct packed {
        logic [31:0] hash;
        logic [8:0]  tile_index;
        logic        in_text;
        logic        len_err;
    } tile_hash_res_t;

    function automatic logic [31:0] fnv1a_step(
        input logic [31:0] acc,
        input logic [7:0]  b
    );
        logic [31:0] x;
        x = acc ^ {24'b0, b};
        return x * FNV_PRIME;
    endfunction

endpackage

// File: rtl/tile_hash_fifo.sv
// First-word fall-through queue of tile hash results.
// Head entry is visible on rdata whenever valid is high.
module tile_hash_fifo
    import gbt_hash_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  tile_hash_res_t wdata,
    input  logic           pop,
    output logic           valid,
    output logic           full,
    output tile_hash_res_t rdata
);

    localparam int AW = $clog2(DEPTH);

    tile_hash_res_t mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           empty;
    logic           do_pop;
    logic           do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid   = !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and storage update; a full queue still accepts when popping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_hash_gen.sv
// Per-tile FNV-1a hash generator between the VRAM snooper and the
// text lookup stage; tags each hash and queues it for the consumer.
module tile_hash_gen
    import gbt_hash_pkg::*;
#(
    parameter int TILE_BYTES = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic [8:0]  in_tile_index,
    input  logic        cfg_enable,
    input  logic        cfg_text_only,
    input  logic [8:0]  cfg_text_tile_start,
    input  logic [8:0]  cfg_text_tile_end,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_hash,
    output logic [8:0]  res_tile_index,
    output logic        res_in_text,
    output logic        res_len_err,
    output logic [15:0] drop_count,
    output logic        busy
);

    localparam int CW = $clog2(TILE_BYTES + 2);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TILE_BYTES + 1);
    localparam logic [CW-1:0] CNT_TILE = CW'(TILE_BYTES);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    logic [0:0]     state_q;
    logic [31:0]    acc_q;
    logic [CW-1:0]  cnt_q;
    logic [8:0]     idx_q;
    logic           pend_q;
    tile_hash_res_t pend_res_q;

    logic           first;
    logic           take;
    logic           done;
    logic           keep;
    logic [31:0]    acc_nx;
    logic [CW-1:0]  cnt_nx;
    logic [8:0]     cur_idx;
    logic           cur_in_text;
    logic           cur_len_err;

    logic           fifo_full;
    logic           pop;
    tile_hash_res_t head;

    // Datapath for the byte presented this cycle.
    always_comb begin
        first = (state_q == S_IDLE) && in_valid && cfg_enable;
        take  = first ||
                ((state_q == S_ACCUM) && in_valid && cfg_enable);
        done  = take && in_last;
        acc_nx = fnv1a_step(first ? FNV_OFFSET : acc_q, in_data);
        if (first) begin
            cnt_nx = CW'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_nx = cnt_q;
        end else begin
            cnt_nx = cnt_q + 1'b1;
        end
        cur_idx     = first ? in_tile_index : idx_q;
        cur_in_text = (cur_idx >= cfg_text_tile_start) &&
                      (cur_idx <= cfg_text_tile_end);
        cur_len_err = (cnt_nx != CNT_TILE);
        keep        = done && !(cfg_text_only && !cur_in_text);
    end

    // Tile FSM, accumulator and byte counter; disable aborts the tile.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= FNV_OFFSET;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            if (!cfg_enable) begin
                state_q <= S_IDLE;
                acc_q   <= FNV_OFFSET;
                cnt_q   <= '0;
            end else if (take) begin
                if (first) begin
                    idx_q <= in_tile_index;
                end
                if (in_last) begin
                    state_q <= S_IDLE;
                    acc_q   <= FNV_OFFSET;
                    cnt_q   <= '0;
                end else begin
                    state_q <= S_ACCUM;
                    acc_q   <= acc_nx;
                    cnt_q   <= cnt_nx;
                end
            end
        end
    end

    // Completed-tile register; its content is pushed the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= 1'b0;
            pend_res_q <= '0;
        end else begin
            pend_q <= keep;
            if (keep) begin
                pend_res_q.hash       <= acc_nx;
                pend_res_q.tile_index <= cur_idx;
                pend_res_q.in_text    <= cur_in_text;
                pend_res_q.len_err    <= cur_len_err;
            end
        end
    end

    // Count results lost to a full queue, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (pend_q && fifo_full && !pop &&
                     drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    assign pop = res_valid && res_ready;

    tile_hash_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pend_q),
        .wdata (pend_res_q),
        .pop   (pop),
        .valid (res_valid),
        .full  (fifo_full),
        .rdata (head)
    );

    assign res_hash       = head.hash;
    assign res_tile_index = head.tile_index;
    assign res_in_text    = head.in_text;
    assign res_len_err    = head.len_err;
    assign busy           = (state_q == S_ACCUM) || pend_q;

endmodule

// File: tb/tb_tile_hash_gen.sv
// Bench for tile_hash_gen: directed cases plus randomized tiles
// checked against a queue-based FNV-1a reference.
module tb_tile_hash_gen;

    localparam int TB = 16;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic [8:0]  in_tile_index;
    logic        cfg_enable;
    logic        cfg_text_only;
    logic [8:0]  cfg_start;
    logic [8:0]  cfg_end;
    logic        res_ready;

    logic        a_valid, b_valid;
    logic [31:0] a_hash, b_hash;
    logic [8:0]  a_idx, b_idx;
    logic        a_txt, b_txt;
    logic        a_le, b_le;
    logic [15:0] a_drop, b_drop;
    logic        a_busy, b_busy;

    always #5 clk = ~clk;

    tile_hash_gen #(.TILE_BYTES(TB), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_tile_index(in_tile_index),
        .cfg_enable(cfg_enable), .cfg_text_only(cfg_text_only),
        .cfg_text_tile_start(cfg_start), .cfg_text_tile_end(cfg_end),
        .res_valid(a_valid), .res_ready(res_ready), .res_hash(a_hash),
        .res_tile_index(a_idx), .res_in_text(a_txt), .res_len_err(a_le),
        .drop_count(a_drop), .busy(a_busy)
    );

    tile_hash_gen #(.TILE_BYTES(1), .FIFO_DEPTH(FD)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_tile_index(in_tile_index),
        .cfg_enable(cfg_enable), .cfg_text_only(cfg_text_only),
        .cfg_text_tile_start(cfg_start), .cfg_text_tile_end(cfg_end),
        .res_valid(b_valid), .res_ready(res_ready), .res_hash(b_hash),
        .res_tile_index(b_idx), .res_in_text(b_txt), .res_len_err(b_le),
        .drop_count(b_drop), .busy(b_busy)
    );

    typedef struct {
        logic [31:0] h;
        logic [8:0]  idx;
        logic        txt;
        logic        le;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_drop = 0;

    function automatic logic [31:0] ref_hash(input logic [7:0] b[$]);
        logic [31:0] h;
        h = 32'h811C9DC5;
        foreach (b[i]) h = (h ^ {24'd0, b[i]}) * 32'h01000193;
        return h;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = 8'd0;
        in_tile_index = 9'd0;
        res_ready = 1'b0;
        cfg_enable = 1'b1;
        cfg_text_only = 1'b0;
        cfg_start = 9'd0;
        cfg_end = 9'd511;
        tick();
        tick();
        rst = 1'b0;
        tick();
        expq.delete();
        model_drop = 0;
    endtask

    // Streams a tile; mode 0 random bytes, 1 ramp 0..n-1, 2 given byte.
    task automatic send(input logic [8:0] idx, input int n,
                        input int mode, input logic [7:0] fixed,
                        input bit gaps);
        logic [7:0] b[$];
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (mode == 1) b.push_back(8'(i));
            else if (mode == 2) b.push_back(fixed);
            else b.push_back(8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 5) == 0) begin
                in_valid = 1'b0;
                in_last = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data = b[i];
            in_last = (i == n - 1);
            in_tile_index = idx;
            tick();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        e.h = ref_hash(b);
        e.idx = idx;
        e.txt = (idx >= cfg_start) && (idx <= cfg_end);
        e.le = (n != TB);
        if (!(cfg_text_only && !e.txt)) begin
            if (expq.size() < FD) expq.push_back(e);
            else model_drop++;
        end
    endtask

    task automatic partial(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data = 8'($urandom_range(0, 255));
            in_last = 1'b0;
            in_tile_index = 9'd77;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        exp_t e;
        int t;
        res_ready = 1'b1;
        while (expq.size() > 0) begin
            t = 0;
            while (!a_valid && t < 20) begin
                tick();
                t++;
            end
            e = expq.pop_front();
            chk({tag, "_valid"}, 64'(a_valid), 64'd1);
            chk({tag, "_hash"}, 64'(a_hash), 64'(e.h));
            chk({tag, "_idx"}, 64'(a_idx), 64'(e.idx));
            chk({tag, "_txt"}, 64'(a_txt), 64'(e.txt));
            chk({tag, "_lenerr"}, 64'(a_le), 64'(e.le));
            if (!a_valid) break;
            tick();
        end
        res_ready = 1'b0;
        tick();
        chk({tag, "_empty"}, 64'(a_valid), 64'd0);
        chk({tag, "_drop"}, 64'(a_drop), 64'(model_drop));
    endtask

    initial begin
        do_reset();
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_hash", 64'(a_hash), 64'd0);
        chk("rst_drop", 64'(a_drop), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_valid1", 64'(b_valid), 64'd0);

        // single byte 'a' on a 1-byte tile instance
        send(9'd5, 1, 2, 8'h61, 1'b0);
        chk("t1_early", 64'(b_valid), 64'd0);
        chk("t1_busy", 64'(b_busy), 64'd1);
        tick();
        chk("t1_valid", 64'(b_valid), 64'd1);
        chk("t1_hash", 64'(b_hash), 64'hE40C292C);
        chk("t1_idx", 64'(b_idx), 64'd5);
        chk("t1_lenerr", 64'(b_le), 64'd0);
        drain("t1");

        do_reset();
        send(9'd1, 1, 2, 8'h00, 1'b0);
        tick();
        chk("t2_hash1", 64'(b_hash), 64'h050C5D1F);
        drain("t2a");
        send(9'd2, 16, 1, 8'h00, 1'b0);
        drain("t2b");

        do_reset();
        send(9'd3, 12, 0, 8'h00, 1'b0);
        send(9'd4, 20, 0, 8'h00, 1'b0);
        drain("t3");

        do_reset();
        for (int i = 0; i < 6; i++) send(9'(10 + i), 16, 0, 8'h00, 1'b0);
        tick();
        tick();
        chk("t4_drop", 64'(a_drop), 64'd2);
        drain("t4");

        do_reset();
        cfg_text_only = 1'b1;
        cfg_start = 9'd32;
        cfg_end = 9'd95;
        send(9'd31, 16, 0, 8'h00, 1'b0);
        send(9'd32, 16, 0, 8'h00, 1'b0);
        send(9'd95, 16, 0, 8'h00, 1'b0);
        send(9'd96, 16, 0, 8'h00, 1'b0);
        chk("t5_count", 64'(expq.size()), 64'd2);
        drain("t5");

        do_reset();
        partial(8);
        chk("t6_busy", 64'(a_busy), 64'd1);
        cfg_enable = 1'b0;
        tick();
        cfg_enable = 1'b1;
        chk("t6_idle", 64'(a_busy), 64'd0);
        tick();
        tick();
        chk("t6_nores", 64'(a_valid), 64'd0);
        send(9'd6, 16, 0, 8'h00, 1'b0);
        drain("t6a");
        partial(8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rstbusy", 64'(a_busy), 64'd0);
        send(9'd7, 16, 1, 8'h00, 1'b0);
        drain("t6b");

        do_reset();
        cfg_start = 9'd32;
        cfg_end = 9'd95;
        for (int r = 0; r < 25; r++) begin
            int k;
            cfg_text_only = 1'($urandom_range(0, 1));
            k = $urandom_range(1, FD);
            for (int j = 0; j < k; j++) begin
                int n;
                n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : TB;
                send(9'($urandom_range(0, 127)), n, 0, 8'h00,
                     1'($urandom_range(0, 1)));
            end
            drain("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
